pipelined_prefix_adder: RTL and testbench

//   Registered WIDTH-bit Kogge-Stone parallel-prefix adder with valid/ready handshake on input and output.

---
 rtl/pipelined_prefix_adder.sv | 171 +++++++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_prefix_adder.sv
// Three-stage Kogge-Stone parallel-prefix adder with valid/ready handshake.
// Stages: bitwise generate/propagate, first SPLIT_LEVEL prefix levels, remaining levels plus sum.

// Kogge-Stone black cell: merges a high group (g_hi, p_hi) with the adjacent lower group.
module prefix_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);
    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;
endmodule

module pipelined_prefix_adder #(
    parameter int WIDTH       = 16,
    parameter int SPLIT_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int LEVELS    = $clog2(WIDTH);
    localparam int S2_LEVELS = LEVELS - SPLIT_LEVEL;

    // The whole pipe freezes, bubbles included, while the consumer holds off a valid result.
    logic advance;
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    // ---------------- Stage S0: bitwise generate / propagate ----------------
    logic             s0_valid;
    logic [WIDTH-1:0] s0_g;
    logic [WIDTH-1:0] s0_p;
    logic             s0_cin;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
        end else if (advance) begin
            s0_valid <= in_valid;
        end
    end

    // NOTE: datapath registers carry no reset; the stage valid bit alone says whether they mean anything.
    always_ff @(posedge clk) begin
        if (advance && in_valid) begin
            s0_g   <= a & b;
            s0_p   <= a ^ b;
            s0_cin <= cin;
        end
    end

    // ---------------- Stage S1: prefix levels 1..SPLIT_LEVEL ----------------
    logic [SPLIT_LEVEL:0][WIDTH-1:0] g_net1;
    logic [SPLIT_LEVEL:0][WIDTH-1:0] p_net1;

    // Carry-in is the bit -1 generate term; folding it into bit 0 lets every node G[i] be C_i.
    assign g_net1[0] = {s0_g[WIDTH-1:1], s0_g[0] | (s0_p[0] & s0_cin)};
    assign p_net1[0] = s0_p;

    for (genvar l = 0; l < SPLIT_LEVEL; l++) begin : g_lvl1
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_cell
                prefix_cell u_cell (
                    .g_hi  (g_net1[l][i]),
                    .p_hi  (p_net1[l][i]),
                    .g_lo  (g_net1[l][i-(1<<l)]),
                    .p_lo  (p_net1[l][i-(1<<l)]),
                    .g_out (g_net1[l+1][i]),
                    .p_out (p_net1[l+1][i])
                );
            end else begin : g_pass
                assign g_net1[l+1][i] = g_net1[l][i];
                assign p_net1[l+1][i] = p_net1[l][i];
            end
        end
    end

    logic             s1_valid;
    logic [WIDTH-1:0] s1_gg;
    logic [WIDTH-1:0] s1_gp;
    logic [WIDTH-1:0] s1_p;
    logic             s1_cin;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= s0_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (advance && s0_valid) begin
            s1_gg  <= g_net1[SPLIT_LEVEL];
            s1_gp  <= p_net1[SPLIT_LEVEL];
            s1_p   <= s0_p;
            s1_cin <= s0_cin;
        end
    end

    // ---------------- Stage S2: remaining prefix levels and sum ----------------
    logic [S2_LEVELS:0][WIDTH-1:0] g_net2;
    logic [S2_LEVELS:0][WIDTH-1:0] p_net2;

    assign g_net2[0] = s1_gg;
    assign p_net2[0] = s1_gp;

    for (genvar l = 0; l < S2_LEVELS; l++) begin : g_lvl2
        localparam int SPAN = 1 << (l + SPLIT_LEVEL);
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= SPAN) begin : g_cell
                prefix_cell u_cell (
                    .g_hi  (g_net2[l][i]),
                    .p_hi  (p_net2[l][i]),
                    .g_lo  (g_net2[l][i-SPAN]),
                    .p_lo  (p_net2[l][i-SPAN]),
                    .g_out (g_net2[l+1][i]),
                    .p_out (p_net2[l+1][i])
                );
            end else begin : g_pass
                assign g_net2[l+1][i] = g_net2[l][i];
                assign p_net2[l+1][i] = p_net2[l][i];
            end
        end
    end

    // Group propagates of the last level have no consumer once all carries are resolved.
    logic unused_group_p;
    assign unused_group_p = ^p_net2[S2_LEVELS];

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             ovf_next;

    assign carry     = g_net2[S2_LEVELS];
    assign sum_next  = s1_p ^ {carry[WIDTH-2:0], s1_cin};
    assign cout_next = carry[WIDTH-1];
    // Signed overflow is exactly carry-into-MSB differing from carry-out-of-MSB.
    assign ovf_next  = carry[WIDTH-1] ^ carry[WIDTH-2];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_next;
                cout <= cout_next;
                ovf  <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench for pipelined_prefix_adder: directed cases, backpressure, bubbles, reset
// mid-flight and randomized traffic on WIDTH=16/8/32 against an arithmetic reference model.
module tb_pipelined_prefix_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected {ovf, cout, sum}, oldest first
    logic [W+1:0] exp_q[$];
    bit           rand_ready = 0;

    int cur_run = 0, last_run = 0, max_run = 0, n_retired = 0, stall_cycles = 0;

    always #5 clk = ~clk;

    pipelined_prefix_adder #(.WIDTH(W), .SPLIT_LEVEL(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer addition, overflow from operand/result signs.
    function automatic logic [W+1:0] model16(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci);
        logic [W:0] full;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        return {(x[W-1] == y[W-1]) && (full[W-1] != x[W-1]), full};
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input bit jitter);
        bit acc;
        int waited;
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        waited = 0;
        forever begin
            #1 acc = in_ready;
            @(posedge clk);
            if (acc) exp_q.push_back(model16(a, b, cin));
            @(negedge clk);
            if (acc) break;
            waited++;
            if (waited > 200) begin
                check("send_timeout", 64'(waited), 64'(0));
                break;
            end
            // Operands may wander while stalled; only the accepting edge's values count.
            if (jitter) begin
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_single(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                              input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        send(va, vb, vc, 0);
        // Count rising edges from the accepting edge (inclusive) until out_valid is seen.
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check("latency_edges", 64'(lat), 64'(3));
        check("direct_sum", 64'(sum), 64'(es));
        check("direct_cout", 64'(cout), 64'(ec));
        check("direct_ovf", 64'(ovf), 64'(eo));
        @(negedge clk);
        idle(2);
    endtask

    always @(negedge clk) if (rand_ready) out_ready = 1'($urandom);

    // Monitor: samples mid-low-phase, after all falling-edge stimulus has settled.
    initial begin
        logic [W+1:0] held;
        bit           held_v;
        held_v = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held_v = 0;
                cur_run = 0;
                continue;
            end
            check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (held_v && out_valid) check("stall_hold", 64'({ovf, cout, sum}), 64'(held));
            held_v = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_valid", 64'(out_valid), 64'(0));
                else check("result", 64'({ovf, cout, sum}), 64'(exp_q.pop_front()));
                n_retired++;
                cur_run++;
            end else begin
                if (cur_run > 0) last_run = cur_run;
                if (cur_run > max_run) max_run = cur_run;
                cur_run = 0;
            end
            if (out_valid && !out_ready) begin
                held = {ovf, cout, sum};
                held_v = 1;
                stall_cycles++;
            end
        end
    end

    // Secondary configurations run concurrently with their own driver and scoreboard.
    for (genvar k = 0; k < 2; k++) begin : g_extra
        localparam int XW = (k == 0) ? 8 : 32;
        localparam int XS = (k == 0) ? 1 : 3;

        logic          x_rst, x_in_valid, x_in_ready, x_cin;
        logic          x_out_valid, x_out_ready, x_cout, x_ovf;
        logic [XW-1:0] x_a, x_b, x_sum;
        logic [XW+1:0] x_q[$];
        bit            done = 0;

        pipelined_prefix_adder #(.WIDTH(XW), .SPLIT_LEVEL(XS)) u_dut (
            .clk       (clk),
            .rst       (x_rst),
            .in_valid  (x_in_valid),
            .in_ready  (x_in_ready),
            .a         (x_a),
            .b         (x_b),
            .cin       (x_cin),
            .out_valid (x_out_valid),
            .out_ready (x_out_ready),
            .sum       (x_sum),
            .cout      (x_cout),
            .ovf       (x_ovf)
        );

        function automatic logic [XW+1:0] model(input logic [XW-1:0] x, input logic [XW-1:0] y,
                                                input logic ci);
            logic [XW:0] full;
            full = {1'b0, x} + {1'b0, y} + {{XW{1'b0}}, ci};
            return {(x[XW-1] == y[XW-1]) && (full[XW-1] != x[XW-1]), full};
        endfunction

        initial begin
            int n;
            bit pend, acc;
            x_rst = 1'b1; x_in_valid = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0;
            x_out_ready = 1'b0;
            repeat (2) @(negedge clk);
            x_rst = 1'b0;
            n = 0;
            pend = 0;
            while (n < 2000) begin
                x_out_ready = 1'($urandom);
                if (!pend && $urandom_range(0, 3) != 0) pend = 1;
                x_in_valid = pend;
                x_a = XW'($urandom); x_b = XW'($urandom); x_cin = 1'($urandom);
                #1 acc = pend && x_in_ready;
                @(posedge clk);
                if (acc) begin
                    x_q.push_back(model(x_a, x_b, x_cin));
                    pend = 0;
                    n++;
                end
                @(negedge clk);
            end
            x_in_valid = 1'b0;
            x_out_ready = 1'b1;
            for (int t = 0; t < 100 && x_q.size() > 0; t++) @(negedge clk);
            check($sformatf("w%0d_drain", XW), 64'(x_q.size()), 64'(0));
            done = 1;
        end

        initial begin
            forever begin
                @(negedge clk);
                #2;
                if (!x_rst && x_out_valid && x_out_ready) begin
                    if (x_q.size() == 0)
                        check($sformatf("w%0d_spurious", XW), 64'(x_out_valid), 64'(0));
                    else
                        check($sformatf("w%0d_result", XW), 64'({x_ovf, x_cout, x_sum}),
                              64'(x_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;

        // Reset, then idle: nothing valid may appear.
        repeat (2) begin
            @(negedge clk);
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_in_ready", 64'(in_ready), 64'(1));
            check("rst_sum", 64'(sum), 64'(0));
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("idle_out_valid", 64'(out_valid), 64'(0));
            check("idle_sum", 64'(sum), 64'(0));
        end

        // Single op and carry / overflow corners.
        run_single(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_single(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_single(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_single(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_single(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Eight back-to-back ops with the consumer always ready.
        last_run = 0;
        for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 0);
        idle(8);
        check("b2b_run_length", 64'(last_run), 64'(8));
        check("b2b_drained", 64'(exp_q.size()), 64'(0));

        // Backpressure: consumer stalls for 4 cycles mid-stream.
        stall_cycles = 0;
        base = n_retired;
        fork
            for (int i = 0; i < 12; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 1);
            begin
                repeat (5) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        idle(8);
        check("bp_stall_cycles", 64'(stall_cycles), 64'(4));
        check("bp_retired", 64'(n_retired - base), 64'(12));
        check("bp_drained", 64'(exp_q.size()), 64'(0));

        // Alternating bubbles: results come out separated by an idle cycle.
        max_run = 0;
        base = n_retired;
        for (int i = 0; i < 6; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), 0);
            idle(1);
        end
        idle(6);
        check("bubble_max_run", 64'(max_run), 64'(1));
        check("bubble_retired", 64'(n_retired - base), 64'(6));

        // Reset with three ops in flight: they must vanish.
        for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 0);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_flush_sum", 64'(sum), 64'(0));
        repeat (8) begin
            @(negedge clk);
            check("rst_flush_valid", 64'(out_valid), 64'(0));
        end

        // Randomized traffic with a 50% consumer.
        rand_ready = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(16'($urandom), 16'($urandom), 1'($urandom), 1);
        end
        @(negedge clk);
        rand_ready = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(negedge clk);
        check("random_drained", 64'(exp_q.size()), 64'(0));

        for (int t = 0; t < 20000 && !(g_extra[0].done && g_extra[1].done); t++) @(negedge clk);
        check("extra_configs_done", 64'(g_extra[0].done && g_extra[1].done), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
